// File: rtl/i2s_out_tx.sv
// I2S transmitter: one-entry holding register feeding a mono-to-stereo serialiser.
// bclk/lrclk are derived by dividing clk; starved frames repeat the last sample.
module i2s_out_tx #(
  parameter int W   = 16,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic [7:0]   underrun_cnt
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(2 * W);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * W - 1);
  localparam logic [SW-1:0] SLOT_W    = SW'(W);

  logic [DW-1:0] div_cnt;
  logic [SW-1:0] slot;
  logic [W-1:0]  cur;
  logic [W-1:0]  holding;
  logic          holding_full;

  logic          wrap;
  logic          fall;
  logic          load;
  logic          accept;
  logic [SW-1:0] slot_next;
  logic [SW-1:0] rel;
  logic [SW-1:0] bit_idx;
  logic          sdata_next;

  assign sample_ready = !holding_full;
  assign accept       = sample_valid && !holding_full;
  assign wrap         = (div_cnt == DIV_LAST);
  assign fall         = wrap && bclk;
  assign load         = fall && (slot == SLOT_LAST);
  assign slot_next    = (slot == SLOT_LAST) ? '0 : slot + SW'(1);

  // Slot n of a channel carries cur[W-n]; slot 0 carries the old cur[0] (one-bit I2S delay).
  always_comb begin
    rel        = (slot_next > SLOT_W) ? slot_next - SLOT_W : slot_next;
    bit_idx    = SLOT_W - rel;
    sdata_next = cur[0];
    if (slot_next != '0) begin
      sdata_next = cur[bit_idx[BW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bclk         <= 1'b0;
      slot         <= SLOT_LAST;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      cur          <= '0;
      holding      <= '0;
      holding_full <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      if (wrap) begin
        bclk <= ~bclk;
      end

      if (fall) begin
        slot  <= slot_next;
        lrclk <= (slot_next >= SLOT_W);
        sdata <= sdata_next;
      end

      if (load) begin
        if (holding_full) begin
          cur          <= holding;
          holding_full <= 1'b0;
        end else if (accept) begin
          cur <= sample_in;
        end else if (underrun_cnt != '1) begin
          underrun_cnt <= underrun_cnt + 8'd1;
        end
      end else if (accept) begin
        holding      <= sample_in;
        holding_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_out_tx.sv
// Directed bench for i2s_out_tx at W=16, DIV=2: slot = 4 cycles, frame = 128 cycles,
// frame loads at cycles 4 + 128k after reset release.
module tb_i2s_out_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [7:0]  underrun_cnt;

  int          t;
  int          checks;
  int          passed;
  int          fails;
  logic [31:0] fbits;
  logic [31:0] flr;
  logic        ready_seen;

  i2s_out_tx #(.W(16), .DIV(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    ready_seen = ready_seen | sample_ready;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  // Slot n (1..31) lands in fbits[32-n]; stops one cycle before the next load edge.
  task automatic capture_frame(input int base);
    for (int n = 1; n < 32; n++) begin
      run_to(base + 4 * n);
      fbits[32 - n] = sdata;
      flr[32 - n]   = lrclk;
    end
    run_to(base + 127);
  endtask

  task automatic load_tick();
    tick();
    fbits[0] = sdata;
    flr[0]   = lrclk;
  endtask

  initial begin
    t = 0; checks = 0; passed = 0; fails = 0;
    fbits = '0; flr = '0; ready_seen = 1'b0;

    // Reset for 3 cycles
    reset = 1'b1;
    repeat (3) tick();
    check("rst_bclk",  32'(bclk), 32'd0);
    check("rst_lrclk", 32'(lrclk), 32'd1);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_urun",  32'(underrun_cnt), 32'd0);

    // Release and accept 8001 before the first load
    reset = 1'b0; t = 0;
    sample_valid = 1'b1; sample_in = 16'h8001;
    tick();
    check("bclk_t1", 32'(bclk), 32'd0);
    check("ready_after_accept", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    tick();
    check("bclk_rise_t2", 32'(bclk), 32'd1);
    tick();
    check("bclk_t3", 32'(bclk), 32'd1);
    tick();
    check("bclk_fall_t4", 32'(bclk), 32'd0);
    check("lrclk_load1", 32'(lrclk), 32'd0);
    check("sdata_slot0_first", 32'(sdata), 32'd0);
    check("ready_after_load1", 32'(sample_ready), 32'd1);
    check("urun_load1", 32'(underrun_cnt), 32'd0);

    // Backpressure: 1234 accepted, 5678 held valid while full
    sample_valid = 1'b1; sample_in = 16'h1234;
    tick();
    check("bp_ready_low", 32'(sample_ready), 32'd0);
    sample_in = 16'h5678;
    ready_seen = 1'b0;
    capture_frame(4);
    check("bp_ready_held_low", 32'(ready_seen), 32'd0);
    check("urun_frame8001", 32'(underrun_cnt), 32'd0);
    load_tick();
    check("bits_8001", fbits, 32'h8001_8001);
    check("lrclk_pattern", flr, 32'h0001_FFFE);
    check("bp_ready_after_load", 32'(sample_ready), 32'd1);
    tick();
    check("bp_5678_accepted", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;

    capture_frame(132);
    load_tick();
    check("bits_1234", fbits, 32'h1234_1234);
    check("urun_after_1234", 32'(underrun_cnt), 32'd0);
    check("ready_after_load3", 32'(sample_ready), 32'd1);

    sample_valid = 1'b1; sample_in = 16'h00FF;
    tick();
    sample_valid = 1'b0;
    capture_frame(260);
    load_tick();
    check("bits_5678", fbits, 32'h5678_5678);
    check("urun_after_5678", 32'(underrun_cnt), 32'd0);

    // Starvation: 00FF repeats and the counter steps once per frame
    for (int i = 1; i <= 3; i++) begin
      capture_frame(388 + 128 * (i - 1));
      load_tick();
      check("bits_00ff_repeat", fbits, 32'h00FF_00FF);
      check("urun_step", 32'(underrun_cnt), 32'(i));
    end

    // Bypass: valid exactly in the load cycle with holding empty
    capture_frame(772);
    check("bypass_ready_pre", 32'(sample_ready), 32'd1);
    sample_valid = 1'b1; sample_in = 16'hA5A5;
    load_tick();
    sample_valid = 1'b0;
    check("bits_00ff_last", fbits, 32'h00FF_00FF);
    check("bypass_urun", 32'(underrun_cnt), 32'd3);
    check("bypass_ready_post", 32'(sample_ready), 32'd1);
    capture_frame(900);
    load_tick();
    check("bits_a5a5", fbits, 32'hA5A5_A5A5);
    check("urun_after_a5a5", 32'(underrun_cnt), 32'd4);

    // Mid-frame reset with BEEF held, asserted during slot 9
    sample_valid = 1'b1; sample_in = 16'hBEEF;
    tick();
    sample_valid = 1'b0;
    check("beef_held", 32'(sample_ready), 32'd0);
    run_to(1065);
    reset = 1'b1;
    tick();
    check("mid_rst_bclk",  32'(bclk), 32'd0);
    check("mid_rst_lrclk", 32'(lrclk), 32'd1);
    check("mid_rst_sdata", 32'(sdata), 32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    check("mid_rst_urun",  32'(underrun_cnt), 32'd0);
    reset = 1'b0; t = 0;
    run_to(4);
    check("post_rst_lrclk", 32'(lrclk), 32'd0);
    check("post_rst_urun", 32'(underrun_cnt), 32'd1);
    capture_frame(4);
    load_tick();
    check("beef_discarded", fbits, 32'h0000_0000);
    check("post_rst_urun2", 32'(underrun_cnt), 32'd2);

    // Saturation over 300 starved frames
    run_to(4 + 128 * 253);
    check("urun_254", 32'(underrun_cnt), 32'd254);
    run_to(4 + 128 * 299);
    check("urun_sat_255", 32'(underrun_cnt), 32'd255);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
